// File: rtl/stage_seq_pkg.sv
// Shared types and helpers for the packet-parser stage sequencer.
`default_nettype none

package stage_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } seq_state_t;

    // clog2 clamped to at least one bit so single-value counters stay legal vectors
    function automatic int safe_clog2(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_sequencer.sv
// One-hot stage-enable sequencer: a tuser header pulse arms it, then each stage
// is enabled for DWELL unstalled cycles, with busy/done/overrun status.
`default_nettype none

module stage_sequencer
    import stage_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int DWELL      = 1,
    parameter bit HOLD_LAST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tuser,
    input  logic                  stall,
    input  logic                  abort,
    output logic [NUM_STAGES-1:0] stage_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int IDX_W = safe_clog2(NUM_STAGES);
    localparam int CNT_W = safe_clog2(DWELL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

    if ((NUM_STAGES < 2) || (NUM_STAGES > 32)) begin : g_bad_num_stages
        $error("stage_sequencer: NUM_STAGES must be in 2..32");
    end
    if ((DWELL < 1) || (DWELL > 16)) begin : g_bad_dwell
        $error("stage_sequencer: DWELL must be in 1..16");
    end

    seq_state_t            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] stage_ready_q, stage_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  overrun_q, overrun_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        done_d        = 1'b0;
        overrun_d     = 1'b0;
        stage_ready_d = '0;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else if (tuser) begin
            state_d   = ARM;
            idx_d     = '0;
            cnt_d     = '0;
            overrun_d = (state_q == ARM) || (state_q == RUN);
        end else if (!stall) begin
            case (state_q)
                ARM: begin
                    state_d = RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                RUN: begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (idx_q == LAST_IDX) begin
                            // HOLD keeps idx at the final stage so the enable stays decoded
                            state_d = HOLD_LAST ? HOLD : IDLE;
                            if (!HOLD_LAST) begin
                                idx_d = '0;
                            end
                        end else begin
                            idx_d  = idx_q + 1'b1;
                            done_d = (idx_d == LAST_IDX);
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ARM) || (state_d == RUN);
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_ready_d[i] = ((state_d == RUN) || (state_d == HOLD)) &&
                               (idx_d == IDX_W'(NUM_STAGES - 1 - i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            stage_ready_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            stage_ready_q <= stage_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign stage_ready = stage_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two configurations driven in parallel and compared
// each cycle against a progress-count reference model.
`default_nettype none

module tb_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tuser = 1'b0;
    logic       stall = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] a_sr;
    logic [5:0] b_sr;
    logic       a_busy, a_done, a_ovr;
    logic       b_busy, b_done, b_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stage_sequencer dut_a (
        .clk(clk), .rst(rst), .tuser(tuser), .stall(stall), .abort(abort),
        .stage_ready(a_sr), .busy(a_busy), .done(a_done), .overrun(a_ovr)
    );

    stage_sequencer #(.NUM_STAGES(6), .DWELL(3), .HOLD_LAST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .tuser(tuser), .stall(stall), .abort(abort),
        .stage_ready(b_sr), .busy(b_busy), .done(b_done), .overrun(b_ovr)
    );

    // Model: mode 0 idle, 1 arming, 2 running, 3 holding; p = unstalled run cycles
    int cfg_n [2] = '{4, 6};
    int cfg_d [2] = '{1, 3};
    int cfg_hl[2] = '{1, 0};
    int m_mode[2];
    int m_p   [2];
    bit m_done[2];
    bit m_ovr [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0;
            m_p[c]    = 0;
            m_done[c] = 1'b0;
            m_ovr[c]  = 1'b0;
        end
    endtask

    task automatic model_step(input bit t, input bit s, input bit a);
        for (int c = 0; c < 2; c++) begin
            m_done[c] = 1'b0;
            m_ovr[c]  = 1'b0;
            if (a) begin
                m_mode[c] = 0;
            end else if (t) begin
                m_ovr[c]  = (m_mode[c] == 1) || (m_mode[c] == 2);
                m_mode[c] = 1;
            end else if (!s && m_mode[c] == 1) begin
                m_mode[c] = 2;
                m_p[c]    = 0;
            end else if (!s && m_mode[c] == 2) begin
                m_p[c]++;
                if (m_p[c] == cfg_n[c] * cfg_d[c])
                    m_mode[c] = (cfg_hl[c] != 0) ? 3 : 0;
                else if (m_p[c] == (cfg_n[c] - 1) * cfg_d[c])
                    m_done[c] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_sr, g_sr, g_busy, g_done, g_ovr;
        string       nm;
        for (int c = 0; c < 2; c++) begin
            nm     = (c == 0) ? "a" : "b";
            g_sr   = (c == 0) ? {28'd0, a_sr} : {26'd0, b_sr};
            g_busy = (c == 0) ? {31'd0, a_busy} : {31'd0, b_busy};
            g_done = (c == 0) ? {31'd0, a_done} : {31'd0, b_done};
            g_ovr  = (c == 0) ? {31'd0, a_ovr} : {31'd0, b_ovr};
            if (m_mode[c] == 2)
                e_sr = 32'd1 << (cfg_n[c] - 1 - m_p[c] / cfg_d[c]);
            else if (m_mode[c] == 3)
                e_sr = 32'd1;
            else
                e_sr = 32'd0;
            chk({nm, "_stage_ready"}, g_sr, e_sr);
            chk({nm, "_busy"}, g_busy, {31'd0, (m_mode[c] == 1) || (m_mode[c] == 2)});
            chk({nm, "_done"}, g_done, {31'd0, m_done[c]});
            chk({nm, "_overrun"}, g_ovr, {31'd0, m_ovr[c]});
            chk({nm, "_onehot0"}, {31'd0, $onehot0(g_sr)}, 32'd1);
        end
    endtask

    task automatic cycle(input bit t, input bit s, input bit a);
        tuser = t;
        stall = s;
        abort = a;
        @(posedge clk);
        model_step(t, s, a);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;

        // single header, then long enough for both configs to finish
        cycle(1'b1, 1'b0, 1'b0);
        idle(22);

        // stall two cycles while stage 2 is asserted
        cycle(1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        idle(22);

        // second header while stage 3 is active
        cycle(1'b1, 1'b0, 1'b0);
        idle(3);
        cycle(1'b1, 1'b0, 1'b0);
        idle(22);

        // abort and tuser together during RUN
        cycle(1'b1, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b1);
        idle(3);

        // asynchronous reset while stage 2 is active
        cycle(1'b1, 1'b0, 1'b0);
        idle(2);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #4;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 1'b0);
        idle(22);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 24) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 59) == 0);
        end
        idle(22);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
